// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and the waveform rule for the PWM peripheral
// and any future timer block built on pwm_timebase.
package pwm_pkg;

  localparam int              PWM_CNT_W            = 8;
  localparam logic [7:0]      DUTY_FULL            = 8'hFF;
  localparam int              PWM_PRESCALE_DEFAULT = 13;

  // Full-scale duty is forced high so a 100% setting has no one-step gap
  // at pwm_cnt==255; otherwise the pin is high while the count is below duty.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if: register-bank inputs coming from the SPI stage and the
// 16 pin drives plus period_start going out to the chip pads.
interface pwm_peripheral_if;
  import pwm_pkg::*;

  logic [7:0]           en_reg_out_7_0;
  logic [7:0]           en_reg_out_15_8;
  logic [7:0]           en_reg_pwm_7_0;
  logic [7:0]           en_reg_pwm_15_8;
  logic [PWM_CNT_W-1:0] pwm_duty_cycle;
  logic [7:0]           out_7_0;
  logic [7:0]           out_15_8;
  logic                 period_start;

  // Register-bank side: drives configuration, observes pins.
  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out_7_0, out_15_8, period_start
  );

  // Peripheral side: consumes configuration, drives pins.
  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out_7_0, out_15_8, period_start
  );

endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus 8-bit period counter. Produces the running
// count, the end-of-period wrap strobe and a registered period_start pulse
// that is high in the cycle where the count first reads 0.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = PWM_PRESCALE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 wrap,
  output logic                 period_start
);

  localparam int             PS_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

  logic [PS_W-1:0]      prescale_cnt_q, prescale_cnt_d;
  logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                 period_start_q, period_start_d;
  logic                 tick;

  // Next-state for prescaler and period counter; tick advances the count.
  always_comb begin
    tick           = (prescale_cnt_q == PS_LAST);
    wrap           = tick && (pwm_cnt_q == '1);
    prescale_cnt_d = tick ? '0 : prescale_cnt_q + PS_W'(1);
    pwm_cnt_d      = tick ? pwm_cnt_q + PWM_CNT_W'(1) : pwm_cnt_q;
    period_start_d = wrap;
  end

  // Counter state; reset aborts the current period and restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_cnt_q <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      prescale_cnt_q <= prescale_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_cnt      = pwm_cnt_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: per-pin select between low, static high and the shared PWM
// waveform, with a registered 16-pin output stage.
// Build option PWM_DUTY_SHADOW_EN: when defined, the duty value is captured
// at each period wrap so every period is glitch-free; when undefined, the
// duty input drives the comparator directly.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = PWM_PRESCALE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  pwm_peripheral_if.slave   bus
);

  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic                 wrap;
  logic                 period_start;
  logic [PWM_CNT_W-1:0] duty_eff;
  logic [15:0]          en_out;
  logic [15:0]          en_pwm;
  logic                 pwm_raw;
  logic [15:0]          pins_q, pins_d;

  pwm_timebase #(
    .PRESCALE_DIV (PRESCALE_DIV)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .pwm_cnt      (pwm_cnt),
    .wrap         (wrap),
    .period_start (period_start)
  );

`ifdef PWM_DUTY_SHADOW_EN
  logic [PWM_CNT_W-1:0] duty_q, duty_d;

  // Duty shadow loads only at the wrap so a mid-period write waits for the
  // next period_start.
  always_comb begin
    duty_d = wrap ? bus.pwm_duty_cycle : duty_q;
  end

  // Duty shadow register.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_eff = duty_q;
`else
  // Without the shadow the wrap strobe has no consumer here.
  logic unused_wrap;
  assign unused_wrap = wrap;
  assign duty_eff    = bus.pwm_duty_cycle;
`endif

  // Pin mux: disabled pins low, enabled static pins high, PWM pins follow
  // the shared waveform so all PWM pins stay in phase.
  always_comb begin
    en_out  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    en_pwm  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    pwm_raw = pwm_level(pwm_cnt, duty_eff);
    pins_d  = en_out & (~en_pwm | {16{pwm_raw}});
  end

  // Registered pin drive; enables are not shadowed and land on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pins_q <= '0;
    end else begin
      pins_q <= pins_d;
    end
  end

  assign bus.out_7_0      = pins_q[7:0];
  assign bus.out_15_8     = pins_q[15:8];
  assign bus.period_start = period_start;

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the register bank written over SPI and produces the 16 chip output pins.
- Each pin is one of three things: forced low, forced high (static enable), or driven by a shared PWM waveform.
- A single 8-bit duty cycle applies to all PWM pins.
- The block sits directly downstream of the SPI register block.
- out_7_0 drives uo_out[7:0]; out_15_8 drives uio_out[7:0].

Parameters:
- PRESCALE_DIV, 13: system clocks per PWM counter step. 10 MHz / 13 / 256 ≈ 3.0 kHz PWM. Legal range 1..65535.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en_reg_out_7_0  in  8  output enable, pins 7..0.
- en_reg_out_15_8  in  8  output enable, pins 15..8.
- en_reg_pwm_7_0  in  8  PWM mode select, pins 7..0.
- en_reg_pwm_15_8  in  8  PWM mode select, pins 15..8.
- pwm_duty_cycle  in  8  duty value; 0x00 = 0%, 0xFF = 100%.
- out_7_0  out  8  pin drive, pins 7..0.
- out_15_8  out  8  pin drive, pins 15..8.
- period_start  out  1  one-cycle pulse at the start of each PWM period.

Behaviour:
- Reset (rst=1 at a clk edge): prescale_cnt=0, pwm_cnt=0, duty_q=0, out_7_0=0, out_15_8=0, period_start=0.
  - A reset asserted mid-period aborts that period.
  - Counting restarts from 0 on the first edge after rst is released.
- Prescaler:
  - prescale_cnt counts 0..PRESCALE_DIV-1, then wraps to 0.
  - tick=1 in the cycle where prescale_cnt==PRESCALE_DIV-1.
  - PRESCALE_DIV=1 gives tick=1 every cycle.
- Period counter:
  - pwm_cnt (8-bit) increments on tick and wraps 255→0.
  - Period = 256*PRESCALE_DIV clocks.
- wrap = tick & (pwm_cnt==255).
- period_start is registered: it is 1 for one cycle after each wrap edge, i.e. the cycle in which pwm_cnt first reads 0.
- Duty capture: duty_q loads pwm_duty_cycle on wrap, so it is stable for the whole period (see Optional Feature).
- Waveform (combinational): pwm_raw = (duty_q==8'hFF) ? 1 : (pwm_cnt < duty_q).
  - duty 0x00: always low.
  - duty d in 1..0xFE: high for d*PRESCALE_DIV clocks per period.
  - duty 0xFF: constant high, with no one-step gap.
- Pin select, per bit i of the 16-bit concatenations {15_8, 7_0}:
  - en_out[i]=0 → 0.
  - en_out[i]=1, en_pwm[i]=0 → 1.
  - en_out[i]=1, en_pwm[i]=1 → pwm_raw.
- Outputs are registered: one clk latency from any change in an enable, pwm_cnt or duty_q to the pin.
- Enable/mode changes are not shadowed; they take effect on the next clk edge, even mid-period.
- All pins in PWM mode are in phase; all share pwm_raw.
- Inputs are clk-domain registers from the SPI stage; no synchronisers are required.

Optional Feature:
- Macro: PWM_DUTY_SHADOW_EN.
- Defined:
  - duty_q updates only on wrap, giving glitch-free periods.
  - A new duty written mid-period appears at the next period_start.
- Undefined:
  - duty_q is not instantiated; pwm_raw uses pwm_duty_cycle directly.
  - A duty change is visible at the pins one clk after the input changes.
- period_start exists in both builds.

Decomposition:
- Package pwm_pkg holds:
  - PWM_CNT_W=8;
  - DUTY_FULL=8'hFF;
  - PWM_PRESCALE_DEFAULT=13;
  - a function pwm_level(cnt, duty) implementing the waveform rule.
- Sub-module pwm_timebase (prescaler, pwm_cnt, tick/wrap/period_start).
  - Parameterised by PRESCALE_DIV.
  - Reused by any future timer block.
- Top level pwm_peripheral contains the duty shadow and the 16-bit pin mux/output register.

Test Plan (PRESCALE_DIV=13, PWM_DUTY_SHADOW_EN defined unless stated):
- Reset: hold rst 3 cycles with all enables 0xFF and duty 0x80 → all outputs 0 and period_start 0 during reset; first period_start at 256*13 clocks after release.
- Static: en_out=0x00A5, en_pwm=0x0000 → out_7_0=0xA5, out_15_8=0x00 one clk after the inputs change; stays constant.
- PWM 50%: en_out=en_pwm=0xFFFF, duty=0x80 → after next period_start, each pin high 1664 clocks, low 1664 clocks; period 3328 clocks.
- Duty extremes: duty 0x00 → pins constant 0; duty 0xFF → pins constant 1 across ≥2 full periods.
- Shadow: duty 0x40 running; write 0xC0 at pwm_cnt=0x10 → current period keeps 832 high clocks; next period has 2496 high clocks.
  - Repeat with the macro undefined → high time changes within 1 clk of the write.
- Mixed and mid-run reset: en_out=0x000F, en_pwm=0x0005, duty 0x40 → pins 0,2 PWM; pins 1,3 high; others 0.
  - Assert rst at pwm_cnt=0x20 → outputs 0 next edge; counter restarts from 0.
